// File: rtl/sha2_digest_tx.sv
// Serialises a latched SHA-256 digest to a UART transmitter, one character per handshake.
// Characters are lowercase ASCII hex (or raw bytes), MSB first, with an optional CR LF trailer.
module sha2_digest_tx #(
    parameter int unsigned DIGEST_BITS = 256,
    parameter bit          HEX_ASCII   = 1'b1,
    parameter bit          APPEND_EOL  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIGEST_BITS-1:0] digest,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             tx_byte,
    output logic                   transmit,
    input  logic                   is_transmitting
);

    localparam int unsigned NUM_BYTES = DIGEST_BITS / 8;
    localparam int unsigned NUM_DIG   = NUM_BYTES * (HEX_ASCII ? 2 : 1);
    localparam int unsigned NUM_CHARS = NUM_DIG + (APPEND_EOL ? 2 : 0);
    localparam int unsigned IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int unsigned STEP      = HEX_ASCII ? 4 : 8;
    localparam int unsigned EOL_POS   = APPEND_EOL ? NUM_DIG : NUM_CHARS - 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
    localparam logic [IDX_W-1:0] EOL_IDX  = IDX_W'(EOL_POS);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    logic [2:0]             state_q, state_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGEST_BITS-1:0] sreg_q, sreg_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic [7:0]             digit_char;
    logic [7:0]             cur_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // 8'h57 + n maps 10..15 onto 'a'..'f'
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // The shift register always presents the current digest character at its top
    always_comb begin
        if (HEX_ASCII) begin
            digit_char = hex_char(sreg_q[DIGEST_BITS-1 -: 4]);
        end else begin
            digit_char = sreg_q[DIGEST_BITS-1 -: 8];
        end
        if (APPEND_EOL && (idx_q >= EOL_IDX)) begin
            cur_char = (idx_q == LAST_IDX) ? 8'h0A : 8'h0D;
        end else begin
            cur_char = digit_char;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        idx_d     = idx_q;
        sreg_d    = sreg_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = digest;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_byte_d = cur_char;
                // A character from an abandoned frame may still be on the line
                if (!is_transmitting) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (is_transmitting) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!is_transmitting) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        sreg_d  = sreg_q << STEP;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            idx_q     <= '0;
            sreg_q    <= '0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            idx_q     <= idx_d;
            sreg_q    <= sreg_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign busy     = busy_q;
    assign done     = (state_q == ST_FIN);
    assign transmit = (state_q == ST_SEND);
    assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_sha2_digest_tx.sv
// Bench for sha2_digest_tx: hex+EOL instance (channel 0) and raw instance (channel 1),
// each driven by a UART model and checked against a character-queue reference.
module tb_sha2_digest_tx;

    localparam int DB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start    [2];
    logic [DB-1:0] digest   [2];
    logic          busy     [2];
    logic          done     [2];
    logic [7:0]    tx_byte  [2];
    logic          transmit [2];
    logic          itx      [2];

    sha2_digest_tx #(.DIGEST_BITS(DB), .HEX_ASCII(1'b1), .APPEND_EOL(1'b1)) u_hex (
        .clk(clk), .rst(rst), .start(start[0]), .digest(digest[0]), .busy(busy[0]),
        .done(done[0]), .tx_byte(tx_byte[0]), .transmit(transmit[0]),
        .is_transmitting(itx[0])
    );

    sha2_digest_tx #(.DIGEST_BITS(DB), .HEX_ASCII(1'b0), .APPEND_EOL(1'b0)) u_raw (
        .clk(clk), .rst(rst), .start(start[1]), .digest(digest[1]), .busy(busy[1]),
        .done(done[1]), .tx_byte(tx_byte[1]), .transmit(transmit[1]),
        .is_transmitting(itx[1])
    );

    logic [7:0] exp_q [2][$];
    logic [7:0] rx_q  [2][$];
    int         ack_cnt [2];
    int         line_cnt[2];
    int         ack_delay[2];
    int         line_len[2];
    int         nchar   [2];
    int         done_cnt[2];
    logic       prev_tx [2];
    logic [7:0] held    [2];
    int         tests;
    int         fails;

    function automatic int frame_len(input int c);
        return (c == 0) ? 66 : 32;
    endfunction

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h61 + 8'(n) - 8'd10);
    endfunction

    function automatic logic [DB-1:0] rand_digest();
        logic [DB-1:0] d;
        for (int i = 0; i < DB / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic void build(input int c, input logic [DB-1:0] d);
        logic [7:0] b;
        exp_q[c].delete();
        rx_q[c].delete();
        for (int i = 0; i < DB / 8; i++) begin
            b = 8'(d >> (DB - 8 - 8 * i));
            if (c == 0) begin
                exp_q[c].push_back(hex(b[7:4]));
                exp_q[c].push_back(hex(b[3:0]));
            end else begin
                exp_q[c].push_back(b);
            end
        end
        if (c == 0) begin
            exp_q[c].push_back(8'h0D);
            exp_q[c].push_back(8'h0A);
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of UART model plus protocol/character checking for both channels
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            if (done[c]) begin
                check("done_queue_empty", 64'(exp_q[c].size()), 64'd0);
                check("done_char_count", 64'(nchar[c]), 64'(frame_len(c)));
                check("done_line_idle", 64'(itx[c]), 64'd0);
                done_cnt[c]++;
            end
            if (transmit[c]) begin
                check("tx_gap", 64'(prev_tx[c] || itx[c] || (ack_cnt[c] != 0)), 64'd0);
                check("char_expected", 64'(exp_q[c].size() != 0), 64'd1);
                if (exp_q[c].size() != 0) check("char_value", 64'(tx_byte[c]),
                                                64'(exp_q[c].pop_front()));
                rx_q[c].push_back(tx_byte[c]);
                held[c] = tx_byte[c];
                nchar[c]++;
                ack_cnt[c] = ack_delay[c];
            end else if (ack_cnt[c] > 0) begin
                check("tx_byte_stable", 64'(tx_byte[c]), 64'(held[c]));
                ack_cnt[c]--;
                if (ack_cnt[c] == 0) begin
                    itx[c] = 1'b1;
                    line_cnt[c] = line_len[c];
                end
            end else if (line_cnt[c] > 0) begin
                line_cnt[c]--;
                if (line_cnt[c] == 0) itx[c] = 1'b0;
            end
            prev_tx[c] = transmit[c];
        end
    endtask

    task automatic start_frame(input int c, input logic [DB-1:0] d, input bit lat);
        digest[c] = d;
        start[c] = 1'b1;
        build(c, d);
        nchar[c] = 0;
        tick();
        start[c] = 1'b0;
        digest[c] = ~d;
        check("busy_after_start", 64'(busy[c]), 64'd1);
        if (lat) begin
            tick();
            check("first_tx_latency", 64'(transmit[c]), 64'd1);
        end
    endtask

    // Returns on the cycle the done pulse is seen
    task automatic wait_done(input int c);
        int d0;
        int n;
        d0 = done_cnt[c];
        n = 0;
        while (done_cnt[c] == d0 && n < 3000) begin
            tick();
            n++;
        end
        check("done_within_budget", 64'(done_cnt[c] - d0), 64'd1);
    endtask

    task automatic finish_frame(input int c);
        wait_done(c);
        tick();
        check("busy_low_after_done", 64'(busy[c]), 64'd0);
    endtask

    task automatic check_reset_outputs(input int c);
        check("rst_busy", 64'(busy[c]), 64'd0);
        check("rst_done", 64'(done[c]), 64'd0);
        check("rst_transmit", 64'(transmit[c]), 64'd0);
        check("rst_tx_byte", 64'(tx_byte[c]), 64'd0);
    endtask

    initial begin
        logic [DB-1:0] d;
        int n;
        int dc;
        tests = 0;
        fails = 0;
        for (int c = 0; c < 2; c++) begin
            start[c] = 1'b1;
            digest[c] = rand_digest();
            itx[c] = 1'b0;
            ack_cnt[c] = 0;
            line_cnt[c] = 0;
            ack_delay[c] = 1;
            line_len[c] = 10;
            nchar[c] = 0;
            done_cnt[c] = 0;
            prev_tx[c] = 1'b0;
            held[c] = 8'h00;
        end
        rst = 1'b1;

        // Reset held with start asserted
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int c = 0; c < 2; c++) check_reset_outputs(c);
        end
        rst = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tick();
        check("idle_busy_hex", 64'(busy[0]), 64'd0);

        // Hex frame with literal pins on the received text
        start_frame(0, {4{64'h0123456789abcdef}}, 1'b1);
        finish_frame(0);
        check("hex_rx_len", 64'(rx_q[0].size()), 64'd66);
        if (rx_q[0].size() == 66) begin
            check("hex_rx0", 64'(rx_q[0][0]), 64'h30);
            check("hex_rx1", 64'(rx_q[0][1]), 64'h31);
            check("hex_rx10", 64'(rx_q[0][10]), 64'h61);
            check("hex_rx15", 64'(rx_q[0][15]), 64'h66);
            check("hex_rx63", 64'(rx_q[0][63]), 64'h66);
            check("hex_rx64", 64'(rx_q[0][64]), 64'h0D);
            check("hex_rx65", 64'(rx_q[0][65]), 64'h0A);
        end

        // Raw frame
        start_frame(1, {8'hFF, 240'h0, 8'hA5}, 1'b1);
        finish_frame(1);
        check("raw_rx_len", 64'(rx_q[1].size()), 64'd32);
        if (rx_q[1].size() == 32) begin
            check("raw_rx0", 64'(rx_q[1][0]), 64'hFF);
            check("raw_rx1", 64'(rx_q[1][1]), 64'h00);
            check("raw_rx31", 64'(rx_q[1][31]), 64'hA5);
        end

        // Start pulsed mid-frame must be ignored
        start_frame(0, rand_digest(), 1'b1);
        n = 0;
        while (nchar[0] < 10 && n < 1000) begin
            tick();
            n++;
        end
        check("reached_char10", 64'(nchar[0] >= 10), 64'd1);
        digest[0] = '1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0);
        // Start coinciding with FIN->IDLE is dropped, then accepted a cycle later
        d = rand_digest();
        digest[0] = d;
        start[0] = 1'b1;
        tick();
        check("start_in_fin_ignored", 64'(busy[0]), 64'd0);
        build(0, d);
        nchar[0] = 0;
        tick();
        start[0] = 1'b0;
        digest[0] = ~d;
        check("start_after_fin_taken", 64'(busy[0]), 64'd1);
        finish_frame(0);
        dc = done_cnt[0];
        for (int k = 0; k < 40; k++) tick();
        check("no_extra_frame", 64'(done_cnt[0]), 64'(dc));

        // Reset mid-frame while a character is still on the line
        start_frame(0, rand_digest(), 1'b1);
        n = 0;
        while (!(nchar[0] >= 6 && itx[0]) && n < 1000) begin
            tick();
            n++;
        end
        check("reached_char6", 64'(nchar[0] >= 6 && itx[0]), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) check_reset_outputs(c);
        start_frame(0, rand_digest(), 1'b0);
        finish_frame(0);

        // Slow acknowledge from the UART
        ack_delay[0] = 3;
        start_frame(0, rand_digest(), 1'b1);
        finish_frame(0);
        ack_delay[0] = 1;

        // Randomised timing, both channels concurrently
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 2; c++) begin
                ack_delay[c] = int'($urandom_range(4, 1));
                line_len[c] = int'($urandom_range(12, 2));
            end
            start_frame(0, rand_digest(), 1'b0);
            start_frame(1, rand_digest(), 1'b0);
            dc = done_cnt[1];
            wait_done(0);
            n = 0;
            while (done_cnt[1] == dc && n < 3000) begin
                tick();
                n++;
            end
            check("raw_done_within_budget", 64'(done_cnt[1] - dc), 64'd1);
            for (int j = 0; j < 4; j++) tick();
            check("rand_busy_low_hex", 64'(busy[0]), 64'd0);
            check("rand_busy_low_raw", 64'(busy[1]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
